// File: rtl/bam_multi.sv
// Multi-channel binary-angle-modulation (BAM) generator.
// Each channel has a shadow duty register written at any time and an active
// duty register that is only reloaded at frame boundaries, so updates never
// disturb a frame in progress. Bit b of the active duty is presented for
// 2^b prescaled ticks; MSB slot first, LSB slot last.
module bam_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                i_clk,
  input  logic                i_arst,
  input  logic                i_on,
  input  logic [2:0]          i_presc_mode,
  input  logic                i_wr_en,
  input  logic [3:0]          i_wr_ch,
  input  logic [WIDTH-1:0]    i_wr_data,
  input  logic [CHANNELS-1:0] i_ch_en,
  output logic                o_bam_enable,
  output logic [CHANNELS-1:0] o_signal,
  output logic                o_frame_done,
  output logic                o_pending
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] TOP_BIT = BW'(WIDTH - 1);
  localparam logic [4:0] CH_LIMIT = 5'(CHANNELS);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  // Per-channel duty storage
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [WIDTH-1:0] active [CHANNELS];

  // Frame-latched configuration
  logic [CHANNELS-1:0] mask_act;
  logic [2:0]          mode_act;

  // Sequencing counters
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] slot_cnt;
  logic [7:0]       presc_cnt;

  logic pending;
  logic frame_done;

  // Decoded control
  logic             run;
  logic             load;
  logic             stop;
  logic             tick;
  logic             slot_end;
  logic             frame_end;
  logic             wr_hit;
  logic [7:0]       presc_last;
  logic [WIDTH-1:0] slot_last;

  // Run/idle state register
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and sequencing strobes; terminal counts derive from the
  // frame-latched mode and the current bit index.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    stop       = 1'b0;
    tick       = 1'b0;
    slot_end   = 1'b0;
    frame_end  = 1'b0;
    presc_last = (8'd1 << mode_act) - 8'd1;
    slot_last  = (WIDTH'(1) << bit_idx) - WIDTH'(1);
    wr_hit     = i_wr_en && ({1'b0, i_wr_ch} < CH_LIMIT);
    case (state)
      ST_IDLE: begin
        if (i_on) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_on) begin
          stop      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          tick      = (presc_cnt == presc_last);
          slot_end  = tick && (slot_cnt == slot_last);
          frame_end = slot_end && (bit_idx == '0);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: frame (re)load, counters, stop clearing, shadow writes.
  // Shadow writes and the pending flag are evaluated after the reload so a
  // write on a frame-end edge lands in the shadow while the active register
  // takes the pre-write value, and pending stays set for the new data.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        shadow[c] <= '0;
        active[c] <= '0;
      end
      mask_act   <= '0;
      mode_act   <= '0;
      bit_idx    <= TOP_BIT;
      slot_cnt   <= '0;
      presc_cnt  <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;

      if (load || frame_end) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          active[c] <= shadow[c];
        end
        mask_act  <= i_ch_en;
        mode_act  <= i_presc_mode;
        bit_idx   <= TOP_BIT;
        slot_cnt  <= '0;
        presc_cnt <= '0;
      end else if (stop) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          active[c] <= '0;
        end
        bit_idx   <= '0;
        slot_cnt  <= '0;
        presc_cnt <= '0;
      end else if (tick) begin
        presc_cnt <= '0;
        if (slot_end) begin
          slot_cnt <= '0;
          bit_idx  <= bit_idx - BW'(1);
        end else begin
          slot_cnt <= slot_cnt + WIDTH'(1);
        end
      end else if (run) begin
        presc_cnt <= presc_cnt + 8'd1;
      end

      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (i_wr_en && (i_wr_ch == 4'(c))) begin
          shadow[c] <= i_wr_data;
        end
      end

      if (wr_hit) begin
        pending <= 1'b1;
      end else if (load || frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // Outputs are decoded from registered state only
  always_comb begin
    run      = (state == ST_RUN);
    o_signal = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      o_signal[c] = active[c][bit_idx] & mask_act[c] & run;
    end
    o_bam_enable = run;
    o_frame_done = frame_done;
    o_pending    = pending;
  end

endmodule

// File: tb/tb_bam_multi.sv
// Self-checking bench for bam_multi (CHANNELS=4, WIDTH=8).
// A frame-time reference model (cycles since frame start, bit derived from
// cumulative slot lengths) is compared every cycle; a vector table and
// hand-written sequences cover reset, reload timing and corner cases.
module tb_bam_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_arst    = 1'b0;
  logic       d_on      = 1'b0;
  logic [2:0] d_mode    = 3'd0;
  logic       d_wr_en   = 1'b0;
  logic [3:0] d_wr_ch   = 4'd0;
  logic [7:0] d_wr_data = 8'd0;
  logic [3:0] d_ch_en   = 4'd0;

  logic       bam_en;
  logic [3:0] sig;
  logic       fdone;
  logic       pend;

  int checks = 0;
  int errors = 0;

  bam_multi #(.CHANNELS(4), .WIDTH(8)) dut (
    .i_clk        (clk),
    .i_arst       (d_arst),
    .i_on         (d_on),
    .i_presc_mode (d_mode),
    .i_wr_en      (d_wr_en),
    .i_wr_ch      (d_wr_ch),
    .i_wr_data    (d_wr_data),
    .i_ch_en      (d_ch_en),
    .o_bam_enable (bam_en),
    .o_signal     (sig),
    .o_frame_done (fdone),
    .o_pending    (pend)
  );

  // Reference model state
  logic       m_run = 1'b0;
  int         m_t = 0;
  logic [7:0] m_shadow [4];
  logic [7:0] m_active [4];
  logic [3:0] m_mask = 4'd0;
  logic [2:0] m_mode = 3'd0;
  logic       m_pend = 1'b0;
  logic       m_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit shown at tick p of a frame: slots are 128,64,...,1 ticks long
  function automatic int bit_at(input int p);
    int b = 7;
    int start = 0;
    while (b > 0 && p >= start + (1 << b)) begin
      start += (1 << b);
      b--;
    end
    return b;
  endfunction

  function automatic logic [3:0] model_sig();
    logic [3:0] s = 4'd0;
    int b;
    if (m_run) begin
      b = bit_at(m_t >> m_mode);
      for (int c = 0; c < 4; c++) s[c] = m_mask[c] & m_active[c][b];
    end
    return s;
  endfunction

  task automatic model_reload();
    for (int c = 0; c < 4; c++) m_active[c] = m_shadow[c];
    m_mask = d_ch_en;
    m_mode = d_mode;
    m_pend = 1'b0;
  endtask

  task automatic model_update();
    logic nd = 1'b0;
    if (d_arst) begin
      m_run = 1'b0; m_t = 0; m_mask = 4'd0; m_mode = 3'd0; m_pend = 1'b0; m_done = 1'b0;
      for (int c = 0; c < 4; c++) begin m_shadow[c] = 8'd0; m_active[c] = 8'd0; end
      return;
    end
    if (!m_run) begin
      if (d_on) begin model_reload(); m_run = 1'b1; m_t = 0; end
    end else if (!d_on) begin
      m_run = 1'b0; m_t = 0;
      for (int c = 0; c < 4; c++) m_active[c] = 8'd0;
    end else begin
      m_t++;
      if (m_t == (255 << m_mode)) begin model_reload(); m_t = 0; nd = 1'b1; end
    end
    m_done = nd;
    if (d_wr_en && d_wr_ch < 4'd4) begin
      m_shadow[d_wr_ch[1:0]] = d_wr_data;
      m_pend = 1'b1;
    end
  endtask

  // One clock: edge, model update, sample #1 later, compare, drop one-shots
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model", {28'd0, bam_en, sig, fdone, pend},
                   {28'd0, m_run, model_sig(), m_done, m_pend});
    d_wr_en = 1'b0;
    d_arst  = 1'b0;
  endtask

  // Count high samples of one channel over len cycles starting at the
  // current sample; report frame_done seen early and on the final step.
  task automatic measure(input int len, input int ch, output int high,
                         output int early, output logic done_end);
    high = 0;
    early = 0;
    for (int i = 0; i < len; i++) begin
      high += int'(sig[ch]);
      step();
      if (i < len - 1 && fdone) early++;
    end
    done_end = fdone;
  endtask

  typedef struct {
    logic       arst;
    logic       on;
    logic [2:0] mode;
    logic       wr_en;
    logic [3:0] wr_ch;
    logic [7:0] wr_data;
    logic [3:0] ch_en;
    logic       exp_en;
    logic [3:0] exp_sig;
    logic       exp_done;
    logic       exp_pend;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int   h;
    int   e;
    logic dn;

    for (int c = 0; c < 4; c++) begin m_shadow[c] = 8'd0; m_active[c] = 8'd0; end

    // arst, on, mode, wr_en, wr_ch, wr_data, ch_en -> en, sig, done, pend
    tbl[0] = '{1'b1, 1'b1, 3'd0, 1'b1, 4'd1, 8'h33, 4'hF, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 3'd0, 1'b1, 4'd0, 8'hA5, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 3'd0, 1'b1, 4'd9, 8'hFF, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 3'd0, 1'b1, 4'd3, 8'h80, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 4'hF, 1'b1, 4'b1001, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 4'hF, 1'b1, 4'b1001, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 4'hF, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 4'h1, 1'b1, 4'b0001, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 4'h1, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 8'h00, 4'h1, 1'b1, 4'b0000, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      d_arst = tbl[i].arst; d_on = tbl[i].on; d_mode = tbl[i].mode;
      d_wr_en = tbl[i].wr_en; d_wr_ch = tbl[i].wr_ch; d_wr_data = tbl[i].wr_data;
      d_ch_en = tbl[i].ch_en;
      step();
      check($sformatf("vec%0d", i), {28'd0, bam_en, sig, fdone, pend},
            {28'd0, tbl[i].exp_en, tbl[i].exp_sig, tbl[i].exp_done, tbl[i].exp_pend});
    end

    // Frame length and duty at 1:1 prescale
    d_on = 1'b0; step();
    d_wr_en = 1'b1; d_wr_ch = 4'd0; d_wr_data = 8'hA5; step();
    d_on = 1'b1; d_mode = 3'd0; d_ch_en = 4'b0001; step();
    measure(255, 0, h, e, dn);
    check("m0_high", h, 165); check("m0_early", e, 0); check("m0_done", dn, 1);
    measure(255, 0, h, e, dn);
    check("m0_high2", h, 165); check("m0_done2", dn, 1);

    // Prescale 1:8
    d_on = 1'b0; step();
    d_mode = 3'd3; d_on = 1'b1; step();
    measure(2040, 0, h, e, dn);
    check("m3_high", h, 1320); check("m3_early", e, 0); check("m3_done", dn, 1);

    // Mid-frame shadow write is deferred to the next frame
    d_on = 1'b0; step();
    d_mode = 3'd0; d_ch_en = 4'b0011; d_on = 1'b1; step();
    repeat (50) step();
    d_wr_en = 1'b1; d_wr_ch = 4'd1; d_wr_data = 8'h80; step();
    check("mid_wr_pend", pend, 1);
    measure(204, 1, h, e, dn);
    check("mid_wr_old", h, 0); check("mid_wr_done", dn, 1); check("mid_wr_pend_clr", pend, 0);
    measure(255, 1, h, e, dn);
    check("mid_wr_new", h, 128);

    // Write coinciding with frame end: old value used for one more frame
    d_ch_en = 4'b0111;
    d_wr_en = 1'b1; d_wr_ch = 4'd2; d_wr_data = 8'h0F; step();
    repeat (253) step();
    d_wr_en = 1'b1; d_wr_ch = 4'd2; d_wr_data = 8'hFF; step();
    check("fe_wr_done", fdone, 1); check("fe_wr_pend", pend, 1);
    measure(255, 2, h, e, dn);
    check("fe_wr_old", h, 15); check("fe_wr_pend_clr", pend, 0);
    measure(255, 2, h, e, dn);
    check("fe_wr_full", h, 255);
    measure(255, 2, h, e, dn);
    check("fe_wr_full2", h, 255);

    // Disable mid-slot, then re-enable from the MSB with retained shadows
    repeat (37) step();
    d_on = 1'b0; step();
    check("off_en", bam_en, 0); check("off_sig", sig, 0);
    d_ch_en = 4'b1111; d_on = 1'b1; step();
    check("reon_en", bam_en, 1); check("reon_sig", sig, 4'b0111);

    // Reset overrides on/write; out-of-range write is ignored
    repeat (20) step();
    d_arst = 1'b1; d_wr_en = 1'b1; d_wr_ch = 4'd9; d_wr_data = 8'hFF; step();
    check("rst_out", {bam_en, sig, fdone, pend}, 7'd0);
    step();
    check("rst_reload_sig", sig, 0); check("rst_reload_en", bam_en, 1);
    d_wr_en = 1'b1; d_wr_ch = 4'd9; d_wr_data = 8'h55; step();
    check("oor_pend", pend, 0);
    measure(255, 1, h, e, dn);
    check("oor_ch1", h, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      d_arst  = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 399) == 0) d_on = ~d_on;
      d_wr_en = ($urandom_range(0, 9) == 0);
      d_wr_ch = 4'($urandom_range(0, 15));
      d_wr_data = 8'($urandom);
      if ($urandom_range(0, 99) == 0) d_mode = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) d_ch_en = 4'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
